// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl: per-channel fade sequencer feeding the pwm threshold array.
// Each channel steps its threshold by +/-1 toward a host-written target once
// every (rate+1) PWM periods. Thresholds are committed together after a
// full scan so pwm never sees a mid-period change.
// Optional feature: define PWM_FADE_IRQ_EN to build the fade-complete irq pulse.
module pwm_fade_ctrl #(
    parameter int unsigned pwm_width  = 3,
    parameter int unsigned num_pwm    = 4,
    parameter int unsigned rate_width = 4,
    localparam int unsigned cw = (num_pwm > 1) ? $clog2(num_pwm) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  period_tick,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [cw-1:0]         wr_chan,
    input  logic [pwm_width-1:0]  wr_target,
    input  logic [rate_width-1:0] wr_rate,
    output logic [pwm_width-1:0]  thres [num_pwm],
    output logic [num_pwm-1:0]    active,
    output logic                  irq
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [cw-1:0] last_idx = cw'(num_pwm - 1);

    state_t                state, state_n;
    logic [cw-1:0]         idx, idx_n;
    logic                  wr_ready_n;
    logic                  wr_fire;

    logic [pwm_width-1:0]  cur      [num_pwm];
    logic [pwm_width-1:0]  tgt      [num_pwm];
    logic [rate_width-1:0] rate     [num_pwm];
    logic [rate_width-1:0] div      [num_pwm];
    logic [pwm_width-1:0]  cur_step [num_pwm];

    assign wr_fire = wr_valid && wr_ready;

    // FSM state, scan index and registered ready flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            wr_ready <= 1'b1;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            wr_ready <= wr_ready_n;
        end
    end

    // Next-state logic: tick starts a scan, one channel per cycle, then commit
    always_comb begin
        state_n    = state;
        idx_n      = idx;
        wr_ready_n = 1'b0;
        case (state)
            IDLE: begin
                if (period_tick) begin
                    state_n = SCAN;
                    idx_n   = '0;
                end
            end
            SCAN: begin
                if (idx == last_idx) begin
                    state_n = COMMIT;
                end else begin
                    idx_n = idx + cw'(1);
                end
            end
            COMMIT: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                idx_n   = '0;
            end
        endcase
        wr_ready_n = (state_n == IDLE);
    end

    // One-step-toward-target value per channel; only used when cur != tgt
    always_comb begin
        for (int i = 0; i < int'(num_pwm); i++) begin
            cur_step[i] = (tgt[i] > cur[i]) ? cur[i] + pwm_width'(1)
                                            : cur[i] - pwm_width'(1);
        end
    end

    // Per-channel state: host writes in IDLE, ramp step/divider in SCAN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(num_pwm); i++) begin
                cur[i]  <= '0;
                tgt[i]  <= '0;
                rate[i] <= '0;
                div[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < int'(num_pwm); i++) begin
                if (wr_fire && (wr_chan == cw'(i))) begin
                    tgt[i]  <= wr_target;
                    rate[i] <= wr_rate;
                    div[i]  <= '0;
                end else if ((state == SCAN) && (idx == cw'(i)) && (cur[i] != tgt[i])) begin
                    if (div[i] == '0) begin
                        cur[i] <= cur_step[i];
                        div[i] <= rate[i];
                    end else begin
                        div[i] <= div[i] - rate_width'(1);
                    end
                end
            end
        end
    end

    // Thresholds update all at once, only at the end of a scan
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(num_pwm); i++) thres[i] <= '0;
        end else if (state == COMMIT) begin
            for (int i = 0; i < int'(num_pwm); i++) thres[i] <= cur[i];
        end
    end

    // Channel is ramping while its current value differs from its target
    always_comb begin
        active = '0;
        for (int i = 0; i < int'(num_pwm); i++) active[i] = (cur[i] != tgt[i]);
    end

`ifdef PWM_FADE_IRQ_EN
    logic step_hit_c;
    logic done_seen;

    // Scanned channel is about to land exactly on its target
    always_comb begin
        step_hit_c = 1'b0;
        for (int i = 0; i < int'(num_pwm); i++) begin
            if ((idx == cw'(i)) && (cur[i] != tgt[i]) && (div[i] == '0) &&
                (cur_step[i] == tgt[i])) begin
                step_hit_c = 1'b1;
            end
        end
    end

    // Completion tracking across one scan and the one-cycle pulse after commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_seen <= 1'b0;
            irq       <= 1'b0;
        end else begin
            irq <= (state == COMMIT) && done_seen;
            if ((state == IDLE) && period_tick) begin
                done_seen <= 1'b0;
            end else if ((state == SCAN) && step_hit_c) begin
                done_seen <= 1'b1;
            end
        end
    end
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Self-checking bench for pwm_fade_ctrl: directed scenarios plus random
// writes/ticks against a tick-count reference model.
module tb_pwm_fade_ctrl;

`ifdef PWM_FADE_IRQ_EN
    localparam bit irq_en = 1'b1;
`else
    localparam bit irq_en = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       period_tick;
    logic       wr_valid;
    logic       wr_valid2;
    logic       wr_ready;
    logic       wr_ready2;
    logic [1:0] wr_chan;
    logic [2:0] wr_target;
    logic [3:0] wr_rate;
    logic [2:0] thres  [4];
    logic [2:0] thres2 [3];
    logic [3:0] active;
    logic [2:0] active2;
    logic       irq;
    logic       irq2;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: value, target, rate and ticks elapsed since the write
    int  m_cur [4];
    int  m_tgt [4];
    int  m_rate[4];
    int  m_n   [4];
    bit  m_irq;

    always #5 clk = ~clk;

    pwm_fade_ctrl dut (
        .clk(clk), .rst_n(rst_n), .period_tick(period_tick),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_chan(wr_chan),
        .wr_target(wr_target), .wr_rate(wr_rate),
        .thres(thres), .active(active), .irq(irq)
    );

    // three channels so a 2-bit channel index can address a missing channel
    pwm_fade_ctrl #(.num_pwm(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .period_tick(period_tick),
        .wr_valid(wr_valid2), .wr_ready(wr_ready2), .wr_chan(wr_chan),
        .wr_target(wr_target), .wr_rate(wr_rate),
        .thres(thres2), .active(active2), .irq(irq2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_cur[i] = 0; m_tgt[i] = 0; m_rate[i] = 0; m_n[i] = 0;
        end
        m_irq = 1'b0;
    endtask

    task automatic model_write(input int ch, input int t, input int r);
        if (ch < 4) begin
            m_tgt[ch] = t; m_rate[ch] = r; m_n[ch] = 0;
        end
    endtask

    // a moving channel steps on ticks 0, r+1, 2(r+1), ... counted from its write
    task automatic model_tick();
        m_irq = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (m_cur[i] != m_tgt[i]) begin
                if ((m_n[i] % (m_rate[i] + 1)) == 0) begin
                    m_cur[i] += (m_tgt[i] > m_cur[i]) ? 1 : -1;
                    if (m_cur[i] == m_tgt[i]) m_irq = 1'b1;
                end
                m_n[i]++;
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [3:0] exp_act;
        exp_act = '0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_thres%0d", tag, i), 32'(thres[i]), 32'(m_cur[i]));
            exp_act[i] = (m_cur[i] != m_tgt[i]);
        end
        check({tag, "_active"}, 32'(active), 32'(exp_act));
        check({tag, "_irq"}, 32'(irq), 32'(irq_en & m_irq));
    endtask

    task automatic write(input int ch, input int t, input int r);
        int w = 0;
        while (!wr_ready && w < 20) begin
            @(negedge clk); w++;
        end
        check("wr_wait", 32'(w < 20), 32'd1);
        wr_chan = 2'(ch); wr_target = 3'(t); wr_rate = 4'(r); wr_valid = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
        model_write(ch, t, r);
    endtask

    // one tick; results checked once the commit is visible, spacing 16 cycles
    task automatic do_tick(input string tag);
        period_tick = 1'b1;
        @(negedge clk);
        period_tick = 1'b0;
        model_tick();
        repeat (5) @(negedge clk);
        check_all(tag);
        @(negedge clk);
        check({tag, "_irq_off"}, 32'(irq), 32'd0);
        repeat (9) @(negedge clk);
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0; period_tick = 1'b0; wr_valid = 1'b0; wr_valid2 = 1'b0;
        wr_chan = '0; wr_target = '0; wr_rate = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all("reset");
        check("reset_ready", 32'(wr_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_ready", 32'(wr_ready), 32'd1);

        // first write: ch2 ramps 1..7 on consecutive ticks
        write(2, 7, 0);
        for (int k = 1; k <= 8; k++) begin
            do_tick("ramp2");
            check("ramp2_val", 32'(thres[2]), 32'((k < 7) ? k : 7));
            check("ramp2_act", 32'(active[2]), 32'(k < 7));
        end

        // rate 2: steps on ticks 1, 4, 7
        write(0, 3, 2);
        for (int k = 1; k <= 7; k++) begin
            do_tick("rate0");
            check("rate0_val", 32'(thres[0]), 32'(1 + (k - 1) / 3));
        end

        // up to 4, retarget down to 1, must not wrap
        write(1, 7, 0);
        repeat (4) do_tick("up1");
        check("up1_val", 32'(thres[1]), 32'd4);
        write(1, 1, 0);
        for (int k = 1; k <= 5; k++) begin
            do_tick("down1");
            check("down1_val", 32'(thres[1]), 32'((k < 3) ? 4 - k : 1));
        end

        // held write behind a scan, plus a tick raised during SCAN
        period_tick = 1'b1;
        @(negedge clk);
        period_tick = 1'b0;
        model_tick();
        wr_chan = 2'd0; wr_target = 3'd0; wr_rate = 4'd1; wr_valid = 1'b1;
        cnt = 0;
        while (!wr_ready && cnt < 20) begin
            period_tick = (cnt == 0);
            @(negedge clk);
            cnt++;
        end
        period_tick = 1'b0;
        check("ready_low_cycles", 32'(cnt), 32'd5);
        @(negedge clk);
        wr_valid = 1'b0;
        model_write(0, 0, 1);
        repeat (9) @(negedge clk);
        check_all("drop");
        repeat (4) do_tick("hs");

        // write and tick in the same IDLE cycle
        wr_chan = 2'd3; wr_target = 3'd5; wr_rate = 4'd0; wr_valid = 1'b1;
        period_tick = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0; period_tick = 1'b0;
        model_write(3, 5, 0);
        model_tick();
        repeat (5) @(negedge clk);
        check_all("wr_tick");
        check("wr_tick_val", 32'(thres[3]), 32'd1);
        repeat (10) @(negedge clk);

        // channel 3 does not exist in the three-channel instance
        check("oor_ready", 32'(wr_ready2), 32'd1);
        wr_chan = 2'd3; wr_target = 3'd6; wr_rate = 4'd0;
        wr_valid = 1'b1; wr_valid2 = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0; wr_valid2 = 1'b0;
        model_write(3, 6, 0);
        repeat (3) do_tick("oor");
        check("oor_active", 32'(active2), 32'd0);
        for (int i = 0; i < 3; i++) check("oor_thres", 32'(thres2[i]), 32'd0);
        check("oor_irq", 32'(irq2), 32'd0);

        // random writes and ticks
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(1, 0) == 1)
                write($urandom_range(3, 0), $urandom_range(7, 0), $urandom_range(3, 0));
            repeat ($urandom_range(3, 1)) do_tick("rnd");
        end

        // reset during the second SCAN cycle
        write(1, 7, 0);
        write(2, 0, 0);
        do_tick("pre_rst");
        period_tick = 1'b1;
        @(negedge clk);
        period_tick = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(wr_ready), 32'd1);
        check_all("post_rst");

        // completion pulse only on the tick that reaches the target
        write(3, 2, 0);
        for (int k = 1; k <= 4; k++) begin
            do_tick("irq3");
        end
        write(3, 2, 0);
        do_tick("irq_same");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // hard time limit so the bench can never hang
    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
